// File: rtl/dff_mem_burst_pkg.sv
// Shared types and elaboration helpers for the burst flip-flop memory.
package dff_mem_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_CLR  = 2'd3
  } state_e;

  // True when d is a power of two no smaller than 2.
  function automatic bit depth_ok(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/dff_mem_burst_if.sv
// Request / write-beat / read-beat bundle between the pin wrapper and the core.
interface dff_mem_burst_if
  import dff_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);

  logic              req_valid;
  logic              req_ready;
  op_e               req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr, req_len, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_len, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, busy
  );

endinterface

// File: rtl/dff_mem_burst_array.sv
// Flip-flop storage: one synchronous write port, one combinational read port.
// Storage is deliberately left without reset; contents are defined by CLEAR.
module dff_mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dff_mem_burst.sv
// Burst-capable flip-flop memory core: request FSM, address/count walker,
// registered read beats and a sequential CLEAR over the whole array.
module dff_mem_burst
  import dff_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic            clk,
  input  logic            rst,
  dff_mem_burst_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("dff_mem_burst: DEPTH must be a power of two >= 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              we_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;

  assign accept_c = bus.req_valid & req_ready_q;

  dff_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .waddr (addr_q),
    .wdata (wdata_c),
    .raddr (addr_q),
    .rdata (rdata_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave a burst on the beat where the remaining count is zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (bus.req_op)
            OP_READ:  state_d = S_RD;
            OP_WRITE: state_d = S_WR;
            OP_CLEAR: state_d = S_CLR;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RD:    if (count_q == '0) state_d = S_IDLE;
      S_WR:    if (bus.wr_valid && (count_q == '0)) state_d = S_IDLE;
      S_CLR:   if (count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; status flags track the next state
  always_comb begin
    addr_d      = addr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    we_c        = 1'b0;
    wdata_c     = bus.wr_data;
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wr_ready_d  = (state_d == S_WR);
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.req_op == OP_CLEAR) begin
            addr_d  = '0;
            count_d = ADDR_W'(DEPTH - 1);
          end else begin
            addr_d  = bus.req_addr;
            count_d = bus.req_len;
          end
        end
      end
      S_RD: begin
        rd_data_d  = rdata_c;
        rd_valid_d = 1'b1;
        addr_d     = addr_q + ADDR_W'(1);
        count_d    = count_q - ADDR_W'(1);
      end
      S_WR: begin
        if (bus.wr_valid) begin
          we_c    = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - ADDR_W'(1);
        end
      end
      S_CLR: begin
        we_c    = 1'b1;
        wdata_c = '0;
        addr_d  = addr_q + ADDR_W'(1);
        count_d = count_q - ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/dff_mem_burst.md
Name: dff_mem_burst

Overview:
Parametrised flip-flop memory core with a request/handshake front end, replacing the fixed 32x8 single-access DFF memory. Supports single or burst reads and writes with auto-increment and wrap-around, plus a sequential CLEAR command. The array is not reset, which saves reset fan-out. Sits behind the tile's pin-level wrapper, which maps ui/uio pins onto the request and data ports.

Parameters:
DATA_W, 8, word width in bits (>=1)
DEPTH, 32, number of words; power of two, >=2 (elaboration assertion)
ADDR_W, $clog2(DEPTH), address and length width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_op  in  2  0=READ, 1=WRITE, 2=CLEAR, 3=reserved
req_addr  in  ADDR_W  burst start address (ignored for CLEAR)
req_len  in  ADDR_W  beats minus one (0 = one beat, DEPTH-1 = full array)
wr_data  in  DATA_W  write beat data
wr_valid  in  1  write beat present
wr_ready  out  1  high only in WRITE state
rd_data  out  DATA_W  read beat data, registered
rd_valid  out  1  one-cycle strobe per read beat; no backpressure
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert by the wrapper): state=IDLE, rd_data=0, rd_valid=0, wr_ready=0, busy=0, req_ready=1, addr/count=0. Array contents are not reset; after power-up they are undefined until a CLEAR.
- Reset mid-burst or mid-clear aborts immediately. Words already written keep their new values; the rest keep their old values.
- Accept = req_valid & req_ready at a rising edge. addr<=req_addr (0 for CLEAR), count<=req_len (DEPTH-1 for CLEAR).
- States: IDLE, RD, WR, CLR. Transitions:
  - IDLE->RD on READ, IDLE->WR on WRITE, IDLE->CLR on CLEAR.
  - Reserved op: accepted, no effect, stays IDLE.
- RD: one beat every cycle. At each edge in RD: rd_data<=mem[addr], rd_valid<=1, addr<=addr+1 mod DEPTH, count--. At the edge where count==0, state<=IDLE.
  - Accept at edge E0 gives rd_valid high from E1 through E(len+1), consecutive.
  - req_ready returns high after E(len+1).
- rd_valid is 0 in every cycle not covered by an RD beat. rd_data holds its last value when rd_valid is low.
- WR: wr_ready=1. Each edge with wr_valid=1 does mem[addr]<=wr_data, advances addr (mod DEPTH), and decrements count. The beat with count==0 returns to IDLE.
  - wr_valid low stalls indefinitely; no timeout.
- CLR: mem[addr]<=0 each cycle, addr 0..DEPTH-1. Exactly DEPTH cycles, then IDLE.
- Wrap-around: address DEPTH-1 increments to 0. A burst longer than the space to the end wraps. A full-depth burst touches every word exactly once.
- Only one operation is in flight at a time. Reads and writes never collide; no bypass path is needed.
- busy == !req_ready at all times.
- Arithmetic: addr and count are ADDR_W bits, unsigned, modulo 2^ADDR_W.

Decomposition:
- Package dff_mem_pkg holds:
  - op_e (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD), 2-bit.
  - state_e (S_IDLE, S_RD, S_WR, S_CLR).
  - The DEPTH power-of-two check function.
- Sub-module dff_mem_array(DATA_W, DEPTH): one synchronous write port (we, waddr, wdata) and a combinational read (raddr -> rdata), with no reset on storage. The top holds the FSM, addr/count registers and the rd_data register.

Test Plan:
- Reset then CLEAR (op=2) -> busy high exactly 32 cycles. Then READ addr=0 len=31 -> 32 consecutive rd_valid beats, all rd_data=0x00.
- WRITE addr=5 len=2, data 0xA1,0xB2,0xC3 with wr_valid low for 2 cycles between beats 1 and 2. Then READ addr=5 len=2 -> first rd_valid exactly 1 cycle after accept; data 0xA1,0xB2,0xC3; addrs 4 and 8 unchanged.
- Wrap: WRITE addr=30 len=3 data 1,2,3,4, then READ addr=30 len=3 -> 1,2,3,4. Addresses 30,31,0,1 hold 1,2,3,4.
- Single beat: READ len=0 -> exactly one rd_valid pulse; req_ready low for one cycle only.
- Reserved op=3 with req_valid -> accepted, busy stays 0, memory unchanged (verified by a full read).
- Assert rst during beat 2 of WRITE addr=10 len=3 (data 0x11,0x22,0x33,0x44) -> outputs reset immediately, state IDLE. Read of 10..13 gives 0x11, 0x22 and old values at 12, 13.
- Parameter sweep DATA_W=16, DEPTH=64: full-depth WRITE of the pattern i*0x0101, then full READ -> exact match.
